// File: rtl/rect_margin_checker.sv
// Margin checker for the rectangle-loop swap engine: accumulates row/column sums of a binary
// matrix streamed one row per cycle, then captures them as reference or compares against it.
module rect_margin_checker #(
   parameter int ROW_LEN = 4,
   parameter int COL_LEN = 4
) (
   input  logic               clk_i,
   input  logic               rst_i,
   input  logic               start_i,
   input  logic               mode_i,
   input  logic               row_valid_i,
   input  logic [COL_LEN-1:0] row_data_i,
   output logic               row_ready_o,
   output logic               busy_o,
   output logic               done_o,
   output logic               match_o,
   output logic               no_ref_o,
   output logic [ROW_LEN-1:0] row_err_o,
   output logic [COL_LEN-1:0] col_err_o
);
   localparam int RSW = $clog2(COL_LEN + 1);
   localparam int CSW = $clog2(ROW_LEN + 1);
   localparam int IW  = $clog2(ROW_LEN);
   localparam logic [IW-1:0] LAST_IDX = IW'(ROW_LEN - 1);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_SCAN = 2'd1,
      S_CMP  = 2'd2,
      S_DONE = 2'd3
   } state_e;

   function automatic logic [RSW-1:0] popcount(input logic [COL_LEN-1:0] v);
      logic [RSW-1:0] n;
      n = {RSW{1'b0}};
      for (int c = 0; c < COL_LEN; c++) begin
         n = n + RSW'(v[c]);
      end
      return n;
   endfunction

   state_e                          state_q, state_d;
   logic                            mode_q, mode_d;
   logic [IW-1:0]                   idx_q, idx_d;
   logic [ROW_LEN-1:0][RSW-1:0]     row_sum_q, row_sum_d;
   logic [COL_LEN-1:0][CSW-1:0]     col_sum_q, col_sum_d;
   logic [ROW_LEN-1:0][RSW-1:0]     ref_row_q, ref_row_d;
   logic [COL_LEN-1:0][CSW-1:0]     ref_col_q, ref_col_d;
   logic                            ref_valid_q, ref_valid_d;
   logic                            row_ready_q, row_ready_d;
   logic                            busy_q, busy_d;
   logic                            done_q, done_d;
   logic                            match_q, match_d;
   logic                            no_ref_q, no_ref_d;
   logic [ROW_LEN-1:0]              row_err_q, row_err_d;
   logic [COL_LEN-1:0]              col_err_q, col_err_d;
   logic [ROW_LEN-1:0]              row_cmp_s;
   logic [COL_LEN-1:0]              col_cmp_s;
   logic                            hs_s;

   assign hs_s = row_valid_i && row_ready_q;

   // Per-index disagreement between the working margins and the stored reference
   always_comb begin
      row_cmp_s = {ROW_LEN{1'b0}};
      col_cmp_s = {COL_LEN{1'b0}};
      for (int r = 0; r < ROW_LEN; r++) begin
         row_cmp_s[r] = (row_sum_q[r] != ref_row_q[r]);
      end
      for (int c = 0; c < COL_LEN; c++) begin
         col_cmp_s[c] = (col_sum_q[c] != ref_col_q[c]);
      end
   end

   // Next-state and next-output computation for the pass sequencer
   always_comb begin
      state_d     = state_q;
      mode_d      = mode_q;
      idx_d       = idx_q;
      row_sum_d   = row_sum_q;
      col_sum_d   = col_sum_q;
      ref_row_d   = ref_row_q;
      ref_col_d   = ref_col_q;
      ref_valid_d = ref_valid_q;
      row_ready_d = row_ready_q;
      busy_d      = busy_q;
      done_d      = done_q;
      match_d     = match_q;
      no_ref_d    = no_ref_q;
      row_err_d   = row_err_q;
      col_err_d   = col_err_q;
      case (state_q)
         S_IDLE: begin
            if (start_i) begin
               state_d     = S_SCAN;
               mode_d      = mode_i;
               idx_d       = {IW{1'b0}};
               row_sum_d   = '0;
               col_sum_d   = '0;
               match_d     = 1'b0;
               no_ref_d    = 1'b0;
               row_err_d   = {ROW_LEN{1'b0}};
               col_err_d   = {COL_LEN{1'b0}};
               row_ready_d = 1'b1;
               busy_d      = 1'b1;
            end else begin
               state_d = S_IDLE;
            end
         end
         S_SCAN: begin
            if (hs_s) begin
               for (int r = 0; r < ROW_LEN; r++) begin
                  if (IW'(r) == idx_q) begin
                     row_sum_d[r] = popcount(row_data_i);
                  end else begin
                     row_sum_d[r] = row_sum_q[r];
                  end
               end
               for (int c = 0; c < COL_LEN; c++) begin
                  col_sum_d[c] = col_sum_q[c] + CSW'(row_data_i[c]);
               end
               if (idx_q == LAST_IDX) begin
                  state_d     = S_CMP;
                  row_ready_d = 1'b0;
               end else begin
                  idx_d = idx_q + IW'(1);
               end
            end else begin
               state_d = S_SCAN;
            end
         end
         S_CMP: begin
            state_d = S_DONE;
            done_d  = 1'b1;
            if (!mode_q) begin
               ref_row_d   = row_sum_q;
               ref_col_d   = col_sum_q;
               ref_valid_d = 1'b1;
               match_d     = 1'b1;
               row_err_d   = {ROW_LEN{1'b0}};
               col_err_d   = {COL_LEN{1'b0}};
            end else if (ref_valid_q) begin
               row_err_d = row_cmp_s;
               col_err_d = col_cmp_s;
               match_d   = ~|{row_cmp_s, col_cmp_s};
            end else begin
               no_ref_d  = 1'b1;
               match_d   = 1'b0;
               row_err_d = {ROW_LEN{1'b0}};
               col_err_d = {COL_LEN{1'b0}};
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
            done_d  = 1'b0;
            busy_d  = 1'b0;
         end
         default: begin
            state_d     = S_IDLE;
            row_ready_d = 1'b0;
            busy_d      = 1'b0;
            done_d      = 1'b0;
         end
      endcase
   end

   // State, working/reference margins and registered outputs
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q     <= S_IDLE;
         mode_q      <= 1'b0;
         idx_q       <= {IW{1'b0}};
         row_sum_q   <= '0;
         col_sum_q   <= '0;
         ref_row_q   <= '0;
         ref_col_q   <= '0;
         ref_valid_q <= 1'b0;
         row_ready_q <= 1'b0;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         match_q     <= 1'b0;
         no_ref_q    <= 1'b0;
         row_err_q   <= {ROW_LEN{1'b0}};
         col_err_q   <= {COL_LEN{1'b0}};
      end else begin
         state_q     <= state_d;
         mode_q      <= mode_d;
         idx_q       <= idx_d;
         row_sum_q   <= row_sum_d;
         col_sum_q   <= col_sum_d;
         ref_row_q   <= ref_row_d;
         ref_col_q   <= ref_col_d;
         ref_valid_q <= ref_valid_d;
         row_ready_q <= row_ready_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         match_q     <= match_d;
         no_ref_q    <= no_ref_d;
         row_err_q   <= row_err_d;
         col_err_q   <= col_err_d;
      end
   end

   assign row_ready_o = row_ready_q;
   assign busy_o      = busy_q;
   assign done_o      = done_q;
   assign match_o     = match_q;
   assign no_ref_o    = no_ref_q;
   assign row_err_o   = row_err_q;
   assign col_err_o   = col_err_q;

endmodule

// File: tb/tb_rect_margin_checker.sv
// Randomized bench for rect_margin_checker: a matrix-level margin model is compared against the
// 4x4 instance every cycle; a 5x3 instance gets directed literal checks.
module tb_rect_margin_checker;
   localparam int R = 4;
   localparam int C = 4;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst, start, mode, row_valid;
   logic [3:0] row_data;
   logic       row_ready, busy, done, match, no_ref;
   logic [3:0] row_err, col_err;

   logic       s_start, s_mode, s_valid;
   logic [2:0] s_data;
   logic       s_ready, s_busy, s_done, s_match, s_noref;
   logic [4:0] s_rerr;
   logic [2:0] s_cerr;

   rect_margin_checker #(.ROW_LEN(4), .COL_LEN(4)) dut (
      .clk_i(clk), .rst_i(rst), .start_i(start), .mode_i(mode),
      .row_valid_i(row_valid), .row_data_i(row_data), .row_ready_o(row_ready),
      .busy_o(busy), .done_o(done), .match_o(match), .no_ref_o(no_ref),
      .row_err_o(row_err), .col_err_o(col_err)
   );

   rect_margin_checker #(.ROW_LEN(5), .COL_LEN(3)) dut6 (
      .clk_i(clk), .rst_i(rst), .start_i(s_start), .mode_i(s_mode),
      .row_valid_i(s_valid), .row_data_i(s_data), .row_ready_o(s_ready),
      .busy_o(s_busy), .done_o(s_done), .match_o(s_match), .no_ref_o(s_noref),
      .row_err_o(s_rerr), .col_err_o(s_cerr)
   );

   int n_checks = 0;
   int n_fail   = 0;
   logic chk_en = 1'b0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [3:0][2:0] row_sums(input logic [3:0][3:0] m);
      logic [3:0][2:0] s;
      for (int r = 0; r < R; r++) s[r] = 3'($countones(m[r]));
      return s;
   endfunction

   function automatic logic [3:0][2:0] col_sums(input logic [3:0][3:0] m);
      logic [3:0][2:0] s;
      s = '0;
      for (int c = 0; c < C; c++)
         for (int r = 0; r < R; r++) s[c] = s[c] + 3'(m[r][c]);
      return s;
   endfunction

   function automatic logic [3:0] differ(input logic [3:0][2:0] a, input logic [3:0][2:0] b);
      logic [3:0] d;
      for (int i = 0; i < 4; i++) d[i] = (a[i] != b[i]);
      return d;
   endfunction

   // Model: what a pass must produce, from the rows it accepted and the stored margins
   logic            m_busy, m_ready, m_done, m_tail, m_mode, m_refv, m_match, m_noref;
   logic [3:0]      m_rerr, m_cerr;
   logic [3:0][3:0] m_rows;
   logic [3:0][2:0] m_ref_rs, m_ref_cs;
   int              m_cnt;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         m_busy <= 1'b0; m_ready <= 1'b0; m_done <= 1'b0; m_tail <= 1'b0;
         m_mode <= 1'b0; m_refv <= 1'b0; m_match <= 1'b0; m_noref <= 1'b0;
         m_rerr <= 4'd0; m_cerr <= 4'd0; m_rows <= '0; m_cnt <= 0;
         m_ref_rs <= '0; m_ref_cs <= '0;
      end else if (m_done) begin
         m_done <= 1'b0;
         m_busy <= 1'b0;
      end else if (m_tail) begin
         m_tail <= 1'b0;
         m_done <= 1'b1;
         if (!m_mode) begin
            m_ref_rs <= row_sums(m_rows);
            m_ref_cs <= col_sums(m_rows);
            m_refv   <= 1'b1;
            m_match  <= 1'b1;
         end else if (m_refv) begin
            m_rerr  <= differ(row_sums(m_rows), m_ref_rs);
            m_cerr  <= differ(col_sums(m_rows), m_ref_cs);
            m_match <= (row_sums(m_rows) == m_ref_rs) && (col_sums(m_rows) == m_ref_cs);
         end else begin
            m_noref <= 1'b1;
         end
      end else if (m_ready) begin
         if (row_valid) begin
            m_rows[m_cnt] <= row_data;
            m_cnt <= m_cnt + 1;
            if (m_cnt == R - 1) begin
               m_ready <= 1'b0;
               m_tail  <= 1'b1;
            end
         end
      end else if (!m_busy && start) begin
         m_busy <= 1'b1; m_ready <= 1'b1; m_cnt <= 0; m_mode <= mode;
         m_match <= 1'b0; m_noref <= 1'b0; m_rerr <= 4'd0; m_cerr <= 4'd0;
      end
   end

   // Every cycle, the 4x4 instance must agree with the model on all outputs
   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", 32'(busy), 32'(m_busy));
         chk("row_ready", 32'(row_ready), 32'(m_ready));
         chk("done", 32'(done), 32'(m_done));
         chk("match", 32'(match), 32'(m_match));
         chk("no_ref", 32'(no_ref), 32'(m_noref));
         chk("row_err", 32'(row_err), 32'(m_rerr));
         chk("col_err", 32'(col_err), 32'(m_cerr));
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wait_idle();
      int k;
      k = 0;
      while (busy && k < 50) begin
         tick();
         k++;
      end
      chk("idle_reached", 32'(busy), 32'd0);
   endtask

   // One pass; vlen>0 fixes the first row_valid values from vpat (bit 0 first)
   task automatic run_pass(input logic md, input logic [3:0][3:0] rows, input int bubble_pct,
                           input logic [15:0] vpat, input int vlen, input int abort_at,
                           input bit poke, output int lat);
      int   r, guard;
      logic hs;
      lat = -1; r = 0; guard = 0;
      wait_idle();
      start = 1'b1; mode = md;
      tick();
      start = 1'b0; mode = 1'b0;
      while (r < R && guard < 200) begin
         if (guard < vlen) row_valid = vpat[guard];
         else row_valid = ($urandom_range(99) >= bubble_pct);
         row_data = row_valid ? rows[r] : 4'($urandom);
         if (poke && r == 1) start = 1'b1;
         hs = row_valid && row_ready;
         tick();
         start = 1'b0;
         guard++;
         if (hs) r++;
         if (abort_at >= 0 && r == abort_at) begin
            row_valid = 1'b0;
            rst = 1'b1;
            #1;
            chk("abort_busy", 32'(busy), 32'd0);
            tick();
            rst = 1'b0;
            return;
         end
      end
      row_valid = 1'b0; row_data = 4'd0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (done) begin
            lat = k;
            break;
         end
      end
      chk("done_seen", 32'(lat != -1), 32'd1);
      if (poke) begin
         start = 1'b1; mode = 1'b0;
         tick();
         start = 1'b0;
      end
   endtask

   task automatic run6(input logic md, input logic [4:0][2:0] rows, output int lat);
      int r, guard;
      r = 0; guard = 0; lat = -1;
      s_start = 1'b1; s_mode = md;
      tick();
      s_start = 1'b0;
      while (r < 5 && guard < 50) begin
         s_valid = 1'b1; s_data = rows[r];
         if (s_ready) r++;
         tick();
         guard++;
      end
      s_valid = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         if (s_done) begin
            lat = k;
            break;
         end
      end
      chk("r6_done_seen", 32'(lat != -1), 32'd1);
   endtask

   function automatic logic [3:0][3:0] try_swap(input logic [3:0][3:0] m);
      logic [3:0][3:0] o;
      int r1, r2, c1, c2;
      o = m;
      for (int t = 0; t < 40; t++) begin
         r1 = $urandom_range(3); r2 = $urandom_range(3);
         c1 = $urandom_range(3); c2 = $urandom_range(3);
         if (r1 != r2 && c1 != c2 && m[r1][c1] == m[r2][c2] && m[r1][c2] == m[r2][c1]
             && m[r1][c1] != m[r1][c2]) begin
            o[r1][c1] = ~m[r1][c1]; o[r1][c2] = ~m[r1][c2];
            o[r2][c1] = ~m[r2][c1]; o[r2][c2] = ~m[r2][c2];
            return o;
         end
      end
      return o;
   endfunction

   initial begin
      #500000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   logic [3:0][3:0] cap, mtx;
   logic [4:0][2:0] m6;
   int              lat;
   logic            md;
   int              abort_at;

   initial begin
      rst = 1'b1; start = 1'b0; mode = 1'b0; row_valid = 1'b0; row_data = 4'd0;
      s_start = 1'b0; s_mode = 1'b0; s_valid = 1'b0; s_data = 3'd0;
      repeat (3) @(posedge clk);
      #1;
      chk_en = 1'b1;
      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_ready", 32'(row_ready), 32'd0);
      chk("rst_match", 32'(match), 32'd0);
      chk("rst_errs", 32'({row_err, col_err}), 32'd0);
      chk("rst_busy6", 32'(s_busy), 32'd0);
      rst = 1'b0;
      tick();

      // Check pass with nothing captured yet
      mtx = {4'b1000, 4'b0100, 4'b0010, 4'b0001};
      run_pass(1'b1, mtx, 0, 16'd0, 0, -1, 1'b0, lat);
      chk("t1_no_ref", 32'(no_ref), 32'd1);
      chk("t1_match", 32'(match), 32'd0);
      chk("t1_errs", 32'({row_err, col_err}), 32'd0);

      // Capture, then two post-swap checks
      cap = {4'b1100, 4'b1010, 4'b0101, 4'b0011};
      run_pass(1'b0, cap, 0, 16'd0, 0, -1, 1'b0, lat);
      chk("t2_latency", 32'(lat), 32'd1);
      chk("t2_cap_match", 32'(match), 32'd1);
      // 0110/1001 in rows 0,1 moves a unit from column 0 to column 3
      mtx = {4'b1100, 4'b1010, 4'b1001, 4'b0110};
      run_pass(1'b1, mtx, 0, 16'd0, 0, -1, 1'b0, lat);
      chk("t2_alt_match", 32'(match), 32'd0);
      chk("t2_alt_row_err", 32'(row_err), 32'd0);
      chk("t2_alt_col_err", 32'(col_err), 32'b1001);
      mtx = {4'b1100, 4'b1010, 4'b0011, 4'b0101};
      run_pass(1'b1, mtx, 0, 16'd0, 0, -1, 1'b0, lat);
      chk("t2_swap_match", 32'(match), 32'd1);
      chk("t2_swap_errs", 32'({row_err, col_err}), 32'd0);

      // Single-bit corruption
      mtx = {4'b1100, 4'b1010, 4'b0101, 4'b0111};
      run_pass(1'b1, mtx, 0, 16'd0, 0, -1, 1'b0, lat);
      chk("t3_match", 32'(match), 32'd0);
      chk("t3_row_err", 32'(row_err), 32'b0001);
      chk("t3_col_err", 32'(col_err), 32'b0100);

      // Bubbles 1,0,0,1,1,0,1 with stray start pulses mid-scan and in the done cycle
      run_pass(1'b0, cap, 0, 16'b1011001, 7, -1, 1'b1, lat);
      chk("t4_latency", 32'(lat), 32'd1);
      chk("t4_match", 32'(match), 32'd1);

      // Reset after two rows of a capture wipes the reference
      run_pass(1'b0, cap, 0, 16'd0, 0, 2, 1'b0, lat);
      run_pass(1'b1, cap, 0, 16'd0, 0, -1, 1'b0, lat);
      chk("t5_no_ref", 32'(no_ref), 32'd1);
      chk("t5_match", 32'(match), 32'd0);

      // 5x3 all-ones: row sums 3, column sums 5
      m6 = {5{3'b111}};
      run6(1'b0, m6, lat);
      chk("t6_cap_match", 32'(s_match), 32'd1);
      chk("t6_latency", 32'(lat), 32'd1);
      tick();
      run6(1'b1, m6, lat);
      chk("t6_chk_match", 32'(s_match), 32'd1);
      chk("t6_chk_errs", 32'({s_rerr, s_cerr, s_noref}), 32'd0);
      tick();
      m6[2] = 3'b110;
      run6(1'b1, m6, lat);
      chk("t6_bad_match", 32'(s_match), 32'd0);
      chk("t6_bad_row_err", 32'(s_rerr), 32'b00100);
      chk("t6_bad_col_err", 32'(s_cerr), 32'b001);

      // Random passes: fresh matrices, margin-preserving swaps, bubbles, aborts
      run_pass(1'b0, cap, 0, 16'd0, 0, -1, 1'b0, lat);
      for (int p = 0; p < 60; p++) begin
         md = 1'($urandom_range(1));
         if (md && $urandom_range(1) == 1) mtx = try_swap(cap);
         else mtx = {4'($urandom), 4'($urandom), 4'($urandom), 4'($urandom)};
         abort_at = ($urandom_range(9) == 0) ? int'($urandom_range(3, 1)) : -1;
         run_pass(md, mtx, int'($urandom_range(60)), 16'd0, 0, abort_at,
                  1'($urandom_range(1)), lat);
         if (abort_at < 0) chk("rand_latency", 32'(lat), 32'd1);
         if (!md && abort_at < 0) cap = mtx;
      end

      tick();
      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
